// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO_DEPTH-word TX FIFO. Serialiser parity and stop-bit mode
// are captured per frame. Bit timing comes from the baud_en strobe.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_en,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_odd,
    input  logic                  cfg_stop2,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  wr_drop,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] shifter, shifter_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt, stop_cnt_d;
    logic                  tx_d, frame_done_d, load;

    // A full FIFO still accepts a write on the clock the serialiser pops.
    assign push = wr_en && (!fifo_full || pop);
    assign head = mem[rd_ptr];
    assign tx_busy = (state != S_IDLE);

    always_comb begin
        unique case ({push, pop})
            2'b10:   level_d = fifo_level + 1'b1;
            2'b01:   level_d = fifo_level - 1'b1;
            default: level_d = fifo_level;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_d;
            fifo_empty <= (level_d == '0);
            fifo_full  <= (level_d == LVL_W'(FIFO_DEPTH));
            wr_drop    <= wr_en && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_bit    <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shifter    <= shifter_d;
            bit_cnt    <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit    <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt   <= stop_cnt_d;
            tx         <= tx_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        // NOTE: every next-value gets its current value first, so no path can infer a latch.
        state_d      = state;
        shifter_d    = shifter;
        bit_cnt_d    = bit_cnt;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt;
        tx_d         = tx;
        frame_done_d = 1'b0;
        load         = 1'b0;
        pop          = 1'b0;

        if (baud_en) begin
            unique case (state)
                S_IDLE: load = !fifo_empty;
                S_START: begin
                    tx_d      = shifter[0];
                    shifter_d = shifter >> 1;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            tx_d    = par_bit;
                            state_d = S_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        tx_d      = shifter[0];
                        shifter_d = shifter >> 1;
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (stop2_q && !stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        load         = !fifo_empty;
                        if (fifo_empty) begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Frame configuration and parity are frozen at pop time.
        if (load) begin
            pop       = 1'b1;
            shifter_d = head;
            par_en_d  = cfg_par_en;
            stop2_d   = cfg_stop2;
            par_bit_d = (^head) ^ cfg_par_odd;
            tx_d      = 1'b0;
            state_d   = S_START;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: 8-bit instance checked per frame at baud edges,
// plus a 7-bit instance checked by an independent mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int DIV   = 8;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, baud_en, cfg_par_en, cfg_par_odd, cfg_stop2, wr_en;
    logic [DW-1:0]    wr_data;
    logic             fifo_full, fifo_empty, wr_drop, tx, tx_busy, frame_done;
    logic [LVL_W-1:0] fifo_level;

    logic             baud7, wr7_en, cfg7_zero;
    logic [6:0]       wr7_data;
    logic             full7, empty7, drop7, tx7, busy7, done7;
    logic [2:0]       level7;

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .baud_en(baud_en), .cfg_par_en(cfg_par_en),
        .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2), .wr_en(wr_en), .wr_data(wr_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .wr_drop(wr_drop), .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    uart_tx_fifo #(.DATA_WIDTH(7), .FIFO_DEPTH(4)) dut7 (
        .clk(clk), .rst(rst), .baud_en(baud7), .cfg_par_en(cfg7_zero),
        .cfg_par_odd(cfg7_zero), .cfg_stop2(cfg7_zero), .wr_en(wr7_en), .wr_data(wr7_data),
        .fifo_full(full7), .fifo_empty(empty7), .fifo_level(level7),
        .wr_drop(drop7), .tx(tx7), .tx_busy(busy7), .frame_done(done7)
    );

    int total = 0;
    int bad   = 0;

    frame_t     exp_q[$];
    logic [6:0] q7[$];
    bit         baud_on = 0, baud_req = 0, gapless = 0, on7 = 0;
    int         div7 = 434;
    bit         in_frame = 0, rx_busy = 0;
    int         mon_cnt = 0, fd_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic frame_t hand(input logic [15:0] bits, input int len);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        return f;
    endfunction

    function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit odd,
                                          input bit s2);
        frame_t f;
        int k;
        f.bits = '0;
        for (int i = 0; i < DW; i++) f.bits[i+1] = d[i];
        k = DW + 1;
        if (pe) begin
            f.bits[k] = (^d) ^ odd;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    // Baud strobes for the 8-bit instance: periodic when enabled, or a single forced pulse.
    initial begin
        int bcnt;
        bcnt    = 0;
        baud_en = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (baud_on) bcnt = (bcnt == DIV - 1) ? 0 : bcnt + 1;
            else bcnt = 0;
            baud_en = (baud_on && bcnt == DIV - 1) || baud_req;
        end
    end

    initial begin
        int c7;
        c7    = 0;
        baud7 = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (on7) c7 = (c7 >= div7 - 1) ? 0 : c7 + 1;
            else c7 = 0;
            baud7 = on7 && (c7 == div7 - 1);
        end
    end

    // Frame monitor: the bit launched by each baud edge is sampled just after that edge.
    initial begin
        frame_t      cur;
        logic [15:0] got;
        got = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_frame = 0;
                mon_cnt  = 0;
                continue;
            end
            if (frame_done) fd_count++;
            if (!baud_en) continue;
            if (in_frame && mon_cnt == cur.len) begin
                check("frame_done_at_end", frame_done, 1'b1);
                check("frame_bits", got, cur.bits);
                if (gapless && exp_q.size() > 0) check("no_gap", tx, 1'b0);
                in_frame = 0;
            end else if (in_frame) begin
                got[mon_cnt] = tx;
                mon_cnt++;
            end
            if (!in_frame && tx == 1'b0) begin
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = hand('x, 11);
                got      = '0;
                mon_cnt  = 1;
                in_frame = 1;
            end
        end
    end

    // Independent receiver for the 7-bit instance: start-edge detect, then mid-bit sampling.
    initial begin
        logic       prev;
        logic [6:0] r;
        logic [6:0] e;
        prev = 1'b1;
        r    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (prev && !tx7) begin
                rx_busy = 1;
                repeat (div7 / 2) @(posedge clk);
                #1;
                check("t6_start", tx7, 1'b0);
                for (int i = 0; i < 7; i++) begin
                    repeat (div7) @(posedge clk);
                    #1;
                    r[i] = tx7;
                end
                repeat (div7) @(posedge clk);
                #1;
                check("t6_stop", tx7, 1'b1);
                e = (q7.size() > 0) ? q7.pop_front() : 7'bx;
                check("t6_word", r, e);
                rx_busy = 0;
            end
            prev = tx7;
        end
    end

    task automatic put(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic put_end();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !in_frame && !tx_busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic put7(input logic [6:0] d);
        @(negedge clk);
        wr7_en   = 1'b1;
        wr7_data = d;
        q7.push_back(d);
        @(negedge clk);
        wr7_en = 1'b0;
    endtask

    task automatic wait_idle7(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (q7.size() == 0 && !rx_busy && !busy7) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fd0;
        bit  hit;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0;
        cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        wr7_en = 1'b0; wr7_data = '0; cfg7_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", wr_drop, 1'b0);
        check("rst_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // T1: 0xA5, even parity, one stop bit.
        baud_on = 1;
        fd0 = fd_count;
        put(8'hA5);
        exp_q.push_back(hand(16'h054A, 11));
        @(posedge clk);
        #1;
        check("t1_level_after_write", fifo_level, 1);
        check("t1_empty_after_write", fifo_empty, 1'b0);
        put_end();
        wait_idle("t1_idle", 400);
        check("t1_frame_done_count", fd_count - fd0, 1);

        // T2: 0x88, odd parity, two stop bits; config flipped mid-frame must not matter.
        cfg_par_odd = 1'b1;
        cfg_stop2   = 1'b1;
        put(8'h88);
        exp_q.push_back(hand(16'h0F10, 12));
        put_end();
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (tx_busy) begin
                hit = 1;
                break;
            end
        end
        check("t2_busy_seen", hit, 1'b1);
        @(negedge clk);
        cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
        wait_idle("t2_idle", 400);
        cfg_par_en = 1'b1;

        // T3: 17 back-to-back writes into an idle FIFO with no baud strobes.
        baud_on = 0;
        repeat (2) @(negedge clk);
        fd0 = fd_count;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(i * 37 + 5);
            if (i < 16) exp_q.push_back(make_frame(8'(i * 37 + 5), 1'b1, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            check("t3_wr_drop", wr_drop, (i == 16));
        end
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check("t3_drop_single_pulse", wr_drop, 1'b0);
        check("t3_level", fifo_level, 16);
        check("t3_full", fifo_full, 1'b1);
        check("t3_empty", fifo_empty, 1'b0);
        check("t3_idle_busy", tx_busy, 1'b0);

        // T4: write on the pop clock of a full FIFO is accepted.
        @(negedge clk);
        baud_req = 1;
        wr_en    = 1'b1;
        wr_data  = 8'hC3;
        exp_q.push_back(make_frame(8'hC3, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("t4_level", fifo_level, 16);
        check("t4_full", fifo_full, 1'b1);
        check("t4_drop", wr_drop, 1'b0);
        check("t4_tx_start", tx, 1'b0);
        @(negedge clk);
        baud_req = 0;
        wr_en    = 1'b0;
        gapless  = 1;
        baud_on  = 1;
        @(posedge clk);
        #1;
        check("t4_busy", tx_busy, 1'b1);
        wait_idle("t3_drain", 6000);
        gapless = 0;
        check("t3_frame_done_count", fd_count - fd0, 17);
        check("t3_empty_after", fifo_empty, 1'b1);

        // T5: reset during data bit 3 of 0x5A with four more words queued.
        baud_on = 0;
        put(8'h5A);
        exp_q.push_back(make_frame(8'h5A, 1'b1, 1'b0, 1'b0));
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        put_end();
        baud_on = 1;
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #2;
            if (in_frame && mon_cnt == 5) begin
                hit = 1;
                break;
            end
        end
        check("t5_reach_bit3", hit, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t5_tx", tx, 1'b1);
        check("t5_level", fifo_level, 0);
        check("t5_busy", tx_busy, 1'b0);
        check("t5_empty", fifo_empty, 1'b1);
        check("t5_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t5_quiet_tx", tx, 1'b1);
        check("t5_quiet_busy", tx_busy, 1'b0);
        put(8'h3C);
        exp_q.push_back(make_frame(8'h3C, 1'b1, 1'b0, 1'b0));
        put_end();
        wait_idle("t5_idle", 400);

        // T6: 7-bit instance, no parity, two divisors, checked by the receiver model.
        baud_on = 0;
        on7     = 1;
        div7    = 434;
        put7(7'h55); put7(7'h2A); put7(7'h7F);
        wait_idle7("t6_idle_434", 20000);
        div7 = 868;
        put7(7'h01); put7(7'h40); put7(7'h33);
        wait_idle7("t6_idle_868", 35000);
        check("t6_level", level7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
